tdc_acq_ctrl: RTL

Measurement sequencer for the delay-line TDC. On a start request it clears and arms the delay-line capture registers and runs a coarse cycle counter for a programmable window. When the captured hit arrives, it registers the coarse count and the thermometer fine code (as a popcount) and delivers one record over a valid/ready interface. A dead time follows each record. The block sits between the capture registers and the readout/FIFO logic.

---
 rtl/tdc_acq_ctrl_if.sv | 25 ++
 rtl/tdc_acq_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/tdc_acq_ctrl_if.sv
// Record bus from the TDC sequencer to readout: one measurement per valid/ready handshake.
// The master holds every field stable while m_valid is high and m_ready is low.
interface tdc_acq_ctrl_if #(
  parameter int TAPS  = 64,
  parameter int WIN_W = 16
);
  localparam int FW = $clog2(TAPS + 1);

  logic             m_valid;
  logic             m_ready;
  logic [WIN_W-1:0] m_coarse;
  logic [FW-1:0]    m_fine;
  logic             m_timeout;
  logic [7:0]       m_seq;

  modport master (
    output m_valid, m_coarse, m_fine, m_timeout, m_seq,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_coarse, m_fine, m_timeout, m_seq,
    output m_ready
  );
endinterface

// File: rtl/tdc_acq_ctrl.sv
// Delay-line TDC sequencer: clear, arm for a window, capture coarse count + fine popcount, emit one record.
// Record valid the cycle after hit/timeout; holds under backpressure, then DEAD_CYC dead cycles before idle.
module tdc_acq_ctrl #(
  parameter int TAPS     = 64,
  parameter int WIN_W    = 16,
  parameter int DEAD_CYC = 4,
  localparam int FW      = $clog2(TAPS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIN_W-1:0]    win_len,
  input  logic                hit,
  input  logic [TAPS-1:0]     therm,
  output logic                clr,
  output logic                arm,
  output logic                busy,
  tdc_acq_ctrl_if.master      m
);

  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ARM, HOLD, DEAD} state_t;

  typedef struct packed {
    logic [WIN_W-1:0] coarse;
    logic [FW-1:0]    fine;
    logic             timeout;
  } rec_t;

  state_t           state, state_nxt;
  rec_t             rec;
  logic [WIN_W-1:0] cnt;
  logic [WIN_W-1:0] w_last;
  logic [DW-1:0]    dcnt;
  logic [7:0]       seq;
  logic             vld;
  logic             win_end;
  logic             hs;

  function automatic logic [FW-1:0] popcount(input logic [TAPS-1:0] v);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < TAPS; i++) n = n + FW'(v[i]);
    return n;
  endfunction

  assign win_end = (cnt == w_last);
  assign hs      = vld && m.m_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: state_nxt = ARM;
      ARM:   if (hit || win_end) state_nxt = HOLD;
      HOLD: begin
        if (hs) begin
          if (DEAD_CYC == 0) state_nxt = IDLE;
          else               state_nxt = DEAD;
        end
      end
      DEAD:  if (dcnt == DEAD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      clr    <= 1'b0;
      arm    <= 1'b0;
      busy   <= 1'b0;
      vld    <= 1'b0;
      rec    <= '0;
      cnt    <= '0;
      w_last <= '0;
      dcnt   <= '0;
      seq    <= '0;
    end else begin
      state <= state_nxt;
      clr   <= (state_nxt == CLEAR);
      arm   <= (state_nxt == ARM);
      busy  <= (state_nxt != IDLE);
      vld   <= (state_nxt == HOLD);
      case (state)
        IDLE: begin
          if (start) begin
            w_last <= (win_len == '0) ? '0 : win_len - WIN_W'(1);
            cnt    <= '0;
          end
        end
        ARM: begin
          cnt <= cnt + WIN_W'(1);
          if (hit) begin
            rec.coarse  <= cnt;
            rec.fine    <= popcount(therm);
            rec.timeout <= 1'b0;
          end else if (win_end) begin
            rec.coarse  <= cnt + WIN_W'(1);
            rec.fine    <= '0;
            rec.timeout <= 1'b1;
          end
        end
        HOLD: begin
          if (hs) begin
            seq  <= seq + 8'd1;
            dcnt <= '0;
          end
        end
        DEAD: dcnt <= dcnt + DW'(1);
        default: ;
      endcase
    end
  end

  assign m.m_valid   = vld;
  assign m.m_coarse  = rec.coarse;
  assign m.m_fine    = rec.fine;
  assign m.m_timeout = rec.timeout;
  assign m.m_seq     = seq;

endmodule
